alu_seq: RTL and testbench

- Parametrised, registered MIPS-style ALU; successor to the 4-bit combinational AND/OR/ADD/SUB slice.
- Adds NOR, SLT and a multi-cycle unsigned shift-add multiply.
- Start/busy/done handshake and registered status flags.
- Sits between the register-file read stage and the writeback mux of the multi-cycle datapath.

---
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for the sequential ALU.
//   master (requester) : drives start, op, a, b; observes results/status.
//   slave  (ALU)       : observes start, op, a, b; drives result, result_hi,
//                        co, ovf, zero, busy, done.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             co;
  logic             ovf;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  result, result_hi, co, ovf, zero, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output result, result_hi, co, ovf, zero, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered MIPS-style ALU (AND/OR/ADD/SUB/SLT/NOR) with a
// multi-cycle unsigned shift-add multiply (MULU).
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; clears outputs, aborts a multiply
//   bus  : alu_seq_if.slave
//          start/op/a/b    request, taken only while busy=0
//          result/result_hi/co/ovf/zero  registered result and flags
//          busy            multiply in progress
//          done            one-cycle pulse, result and flags valid
// Single-cycle ops finish with latency 1; MULU takes WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MULU = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  // Signed overflow of x + y giving s, from the sign bits alone.
  function automatic logic add_ovf(input logic xm, input logic ym, input logic sm);
    return (xm == ym) && (sm != xm);
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               co_q, co_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]     add_sum, sub_sum, step_sum;
  logic               add_v, sub_v, slt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_co, alu_ovf;
  logic [2*WIDTH-1:0] prod_step;

  // Single-cycle datapath
  always_comb begin
    add_sum = {1'b0, bus.a} + {1'b0, bus.b};
    sub_sum = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
    add_v   = add_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], add_sum[WIDTH-1]);
    sub_v   = add_ovf(bus.a[WIDTH-1], ~bus.b[WIDTH-1], sub_sum[WIDTH-1]);
    // Sign of (a-b) corrected by overflow gives the true signed less-than.
    slt     = sub_sum[WIDTH-1] ^ sub_v;

    alu_res = '0;
    alu_co  = 1'b0;
    alu_ovf = 1'b0;
    case (bus.op)
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_NOR: alu_res = ~(bus.a | bus.b);
      OP_ADD: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_co  = add_sum[WIDTH];
        alu_ovf = add_v;
      end
      OP_SUB: begin
        alu_res = sub_sum[WIDTH-1:0];
        alu_co  = sub_sum[WIDTH];
        alu_ovf = sub_v;
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      default: alu_res = '0;
    endcase
  end

  // Multiply step: prod holds {partial high, remaining multiplier bits}.
  // Add the multiplicand into the high half when the multiplier LSB is set,
  // then shift the whole thing right, carry included.
  always_comb begin
    step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {step_sum, prod_q[WIDTH-1:1]};
  end

  // Next-state and output registers
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    co_d        = co_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MULU) begin
            mcand_d = bus.a;
            prod_d  = {{WIDTH{1'b0}}, bus.b};
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = MUL;
          end else begin
            result_d    = alu_res;
            result_hi_d = '0;
            co_d        = alu_co;
            ovf_d       = alu_ovf;
            zero_d      = (alu_res == '0);
            done_d      = 1'b1;
          end
        end
      end
      MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          result_d    = prod_step[WIDTH-1:0];
          result_hi_d = prod_step[2*WIDTH-1:WIDTH];
          co_d        = 1'b0;
          ovf_d       = 1'b0;
          zero_d      = (prod_step == '0);
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Multiplier working registers are only meaningful in MUL, so no reset.
  always_ff @(posedge clk) begin
    mcand_q <= mcand_d;
    prod_q  <= prod_d;
    cnt_q   <= cnt_d;
  end

  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq at WIDTH=4, directed vectors
// plus randomized operations against an integer reference model.
module tb_alu_seq;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: returns {hi, result, co, ovf, zero} from plain integer maths.
  function automatic logic [10:0] ref_model(input logic [2:0] op,
                                            input logic [3:0] x, input logic [3:0] y);
    int ua, ub, sa, sb, s, r, hi, p;
    bit c, o, z;
    ua = int'(x); ub = int'(y);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    r = 0; hi = 0; c = 0; o = 0;
    case (op)
      3'b000: r = ua & ub;
      3'b001: r = ua | ub;
      3'b100: r = 15 - (ua | ub);
      3'b010: begin
        s = ua + ub; r = s % 16; c = (s >= 16);
        o = (sa + sb > 7) || (sa + sb < -8);
      end
      3'b110: begin
        s = ua + (15 - ub) + 1; r = s % 16; c = (s >= 16);
        o = (sa - sb > 7) || (sa - sb < -8);
      end
      3'b111: r = (sa < sb) ? 1 : 0;
      3'b011: begin
        p = ua * ub; r = p % 16; hi = p / 16;
      end
      default: r = 0;
    endcase
    z = (r == 0) && (hi == 0);
    return {hi[3:0], r[3:0], c, o, z};
  endfunction

  function automatic logic [10:0] observed();
    return {bus.result_hi, bus.result, bus.co, bus.ovf, bus.zero};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [2:0] o,
                       input logic [3:0] x, input logic [3:0] y);
    bus.start = s; bus.op = o; bus.a = x; bus.b = y;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 3'b010, 4'h5, 4'h1);
    tick(); tick();
    vectors++;
    if ({observed(), bus.busy, bus.done} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", {observed(), bus.busy, bus.done}, 13'h0);
    end
    drive(1'b0, 3'b000, 4'h0, 4'h0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [2:0] ops [11] = '{3'b010, 3'b010, 3'b110, 3'b110, 3'b000, 3'b001,
                             3'b100, 3'b111, 3'b111, 3'b111, 3'b101};
    logic [3:0] as  [11] = '{4'h5, 4'h7, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'hF, 4'h7, 4'h3};
    logic [3:0] bs  [11] = '{4'hF, 4'h1, 4'h5, 4'hF, 4'h4, 4'h1, 4'h0, 4'hF, 4'h5, 4'h8, 4'h9};
    // Expected {result, co, ovf} worked out by hand.
    logic [5:0] ex  [11] = '{{4'h4,2'b10}, {4'h8,2'b01}, {4'h0,2'b10}, {4'h6,2'b00},
                             {4'h4,2'b00}, {4'h5,2'b00}, {4'hA,2'b00}, {4'h0,2'b00},
                             {4'h1,2'b00}, {4'h0,2'b00}, {4'h0,2'b00}};
    logic [12:0] want, got;
    logic [10:0] held;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, ops[i], as[i], bs[i]);
      tick();
      drive(1'b0, 3'b000, 4'h0, 4'h0);
      want = {4'h0, ex[i], (ex[i][5:2] == 4'h0), 1'b0, 1'b1};
      got  = {observed(), bus.busy, bus.done};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL directed_%0d op=%b a=%h b=%h: got %h want %h", i, ops[i], as[i], bs[i], got, want);
      end
      held = observed();
      tick();
      vectors++;
      if ({observed(), bus.done} !== {held, 1'b0}) begin
        miscompares++;
        $display("FAIL hold_%0d: got %h want %h", i, {observed(), bus.done}, {held, 1'b0});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] o;
    logic [3:0] x, y;
    logic [12:0] want, got;
    for (int i = 0; i < 40; i++) begin
      do o = 3'($urandom_range(0, 7)); while (o == 3'b011);
      x = 4'($urandom); y = 4'($urandom);
      drive(1'b1, o, x, y);
      tick();
      want = {ref_model(o, x, y), 1'b0, 1'b1};
      got  = {observed(), bus.busy, bus.done};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL b2b_%0d op=%b a=%h b=%h: got %h want %h", i, o, x, y, got, want);
      end
    end
    drive(1'b0, 3'b000, 4'h0, 4'h0);
    tick();
  endtask

  task automatic test_mulu_one(input logic [3:0] x, input logic [3:0] y,
                               input logic [7:0] prod, input bit noisy);
    logic [10:0] held, want;
    int dones;
    drive(1'b1, 3'b011, x, y);
    tick();                                   // edge k
    if (!noisy) drive(1'b0, 3'b000, 4'h0, 4'h0);
    held  = observed();
    dones = 0;
    vectors++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      miscompares++;
      $display("FAIL mul_start a=%h b=%h: busy/done got %b want 10", x, y, {bus.busy, bus.done});
    end
    for (int i = 1; i < W; i++) begin
      if (noisy) drive(1'b1, 3'b010, 4'($urandom), 4'($urandom));
      tick();
      if (bus.done) dones++;
      vectors++;
      if ({observed(), bus.busy} !== {held, 1'b1}) begin
        miscompares++;
        $display("FAIL mul_hold_%0d a=%h b=%h: got %h want %h", i, x, y, {observed(), bus.busy}, {held, 1'b1});
      end
    end
    if (noisy) drive(1'b1, 3'b110, 4'($urandom), 4'($urandom));
    tick();                                   // edge k+W
    drive(1'b0, 3'b000, 4'h0, 4'h0);
    want = {prod, 1'b0, 1'b0, (prod == 8'h0)};
    vectors++;
    if ({observed(), bus.busy, bus.done} !== {want, 2'b01}) begin
      miscompares++;
      $display("FAIL mul_done a=%h b=%h: got %h want %h", x, y, {observed(), bus.busy, bus.done}, {want, 2'b01});
    end
    tick();
    if (bus.done) dones++;
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL mul_extra_done a=%h b=%h: got %0d extra pulses want 0", x, y, dones);
    end
  endtask

  task automatic test_mulu();
    logic [3:0] x, y;
    logic [10:0] m;
    test_mulu_one(4'h5, 4'hF, 8'h4B, 1'b0);
    test_mulu_one(4'hF, 4'hF, 8'hE1, 1'b0);
    test_mulu_one(4'h0, 4'h9, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      x = 4'($urandom); y = 4'($urandom);
      m = ref_model(3'b011, x, y);
      test_mulu_one(x, y, m[10:3], 1'b0);
    end
  endtask

  task automatic test_mul_ignore();
    test_mulu_one(4'h5, 4'hF, 8'h4B, 1'b1);
    test_mulu_one(4'hB, 4'h7, 8'h4D, 1'b1);
  endtask

  task automatic test_start_on_done();
    logic [12:0] got, want;
    drive(1'b1, 3'b011, 4'h3, 4'h3);
    tick();
    drive(1'b0, 3'b000, 4'h0, 4'h0);
    repeat (W) tick();                        // now in the done cycle
    vectors++;
    if ({bus.done, bus.busy, bus.result} !== {2'b10, 4'h9}) begin
      miscompares++;
      $display("FAIL done_cycle_mul: got %h want %h", {bus.done, bus.busy, bus.result}, {2'b10, 4'h9});
    end
    drive(1'b1, 3'b010, 4'h6, 4'h7);
    tick();
    drive(1'b0, 3'b000, 4'h0, 4'h0);
    got  = {observed(), bus.busy, bus.done};
    want = {4'h0, 4'hD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL start_on_done: got %h want %h", got, want);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    logic [12:0] got, want;
    int dones;
    drive(1'b1, 3'b011, 4'hF, 4'hF);
    tick();                                   // edge k
    drive(1'b0, 3'b000, 4'h0, 4'h0);
    tick();                                   // edge k+1
    rst = 1'b1;
    tick();                                   // edge k+2
    rst = 1'b0;
    vectors++;
    if ({observed(), bus.busy, bus.done} !== 13'h0) begin
      miscompares++;
      $display("FAIL abort_state: got %h want %h", {observed(), bus.busy, bus.done}, 13'h0);
    end
    drive(1'b1, 3'b010, 4'h2, 4'h3);
    tick();                                   // edge k+3
    drive(1'b0, 3'b000, 4'h0, 4'h0);
    got  = {observed(), bus.busy, bus.done};
    want = {4'h0, 4'h5, 3'b000, 2'b01};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL abort_then_add: got %h want %h", got, want);
    end
    dones = 0;
    repeat (W + 2) begin
      tick();
      if (bus.done || bus.busy) dones++;
    end
    vectors++;
    if (dones !== 0 || bus.result !== 4'h5) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d stray cycles result %h want 0 and 5", dones, bus.result);
    end
  endtask

  initial begin
    drive(1'b0, 3'b000, 4'h0, 4'h0);
    test_reset();
    test_directed();
    test_back_to_back();
    test_mulu();
    test_mul_ignore();
    test_start_on_done();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
